// File: rtl/positron_layer_folded.sv
// positron_layer_folded: buffers one frame, replays it over NB_PASSES lane passes,
// gathers lane results and drains them downstream. Option macro: POSITRON_LAYER_RELU_EN.
module positron_layer_folded #(
  parameter int POSIT_WIDTH = 16,
  parameter int NB_UPSTREAM = 784,
  parameter int NB_LANES    = 4,
  parameter int NB_PASSES   = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic                            rtr_o,
  input  logic                            rts_i,
  input  logic                            eow_i,
  input  logic [POSIT_WIDTH-1:0]          posit_i,
  input  logic                            lane_rtr_i,
  output logic                            lane_rts_o,
  output logic                            lane_sow_o,
  output logic                            lane_eow_o,
  output logic [POSIT_WIDTH-1:0]          lane_posit_o,
  output logic [$clog2(NB_PASSES):0]      lane_pass_o,
  input  logic                            lane_res_rts_i,
  input  logic [NB_LANES*POSIT_WIDTH-1:0] lane_res_i,
  input  logic                            rtr_i,
  output logic                            rts_o,
  output logic                            eow_o,
  output logic [POSIT_WIDTH-1:0]          posit_o
);
  localparam int W  = POSIT_WIDTH;
  localparam int NN = NB_LANES * NB_PASSES;
  localparam int AW = (NB_UPSTREAM > 1) ? $clog2(NB_UPSTREAM) : 1;
  localparam int OW = (NN > 1) ? $clog2(NN) : 1;
  localparam int PW = $clog2(NB_PASSES) + 1;

  typedef enum logic [1:0] {
    FILL, WAIT_RES, REPLAY, DRAIN
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  frame_mem [NB_UPSTREAM];
  logic [W-1:0]  res_mem [NN];
  logic [AW-1:0] wc, rc, last_idx, rd_addr;
  logic [OW-1:0] oc, res_base;
  logic [PW-1:0] pass;
  logic [W-1:0]  rd_data, drain_word;
  logic          tlast, rd_valid, rd_en;
  logic          fill_acc, fill_last, res_acc;
  logic          pass_last, rp_last, drain_last;

  assign fill_acc   = (state == FILL) & rts_i & lane_rtr_i;
  assign fill_last  = eow_i | (wc == AW'(NB_UPSTREAM - 1));
  assign res_acc    = (state == WAIT_RES) & lane_res_rts_i;
  assign pass_last  = (pass == PW'(NB_PASSES - 1));
  assign rp_last    = (rc == last_idx);
  assign drain_last = (oc == OW'(NN - 1));
  // fetch ahead so a ready lane sees back-to-back words
  assign rd_en   = (state == REPLAY) &
                   (~rd_valid | (lane_rtr_i & ~rp_last));
  assign rd_addr = rd_valid ? rc + AW'(1) : rc;
  assign res_base = OW'(pass) * OW'(NB_LANES);

`ifdef POSITRON_LAYER_RELU_EN
  assign drain_word =
    (res_mem[oc][W-1] && res_mem[oc] != {1'b1, {(W-1){1'b0}}})
    ? '0 : res_mem[oc];
`else
  assign drain_word = res_mem[oc];
`endif

  // frame buffer: write on accept, registered read for replay
  always_ff @(posedge clk) begin
    if (fill_acc)
      frame_mem[wc] <= posit_i;
    if (rd_en)
      rd_data <= frame_mem[rd_addr];
  end

  // lane results stored pass-major, lane-minor
  always_ff @(posedge clk) begin
    if (res_acc)
      for (int k = 0; k < NB_LANES; k++)
        res_mem[res_base + OW'(k)] <= lane_res_i[k*W +: W];
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  // next-state
  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:
        if (fill_acc && fill_last) state_nx = WAIT_RES;
      WAIT_RES:
        if (lane_res_rts_i)
          state_nx = pass_last ? DRAIN : REPLAY;
      REPLAY:
        if (rd_valid && lane_rtr_i && rp_last)
          state_nx = WAIT_RES;
      DRAIN:
        if (rtr_i && drain_last) state_nx = FILL;
    endcase
  end

  // counters, pass index, captured length and tlast
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wc       <= '0;
      rc       <= '0;
      last_idx <= '0;
      pass     <= '0;
      oc       <= '0;
      tlast    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (fill_acc) begin
        if (fill_last) begin
          wc       <= '0;
          last_idx <= wc;
          tlast    <= eow_i;
        end else begin
          wc <= wc + AW'(1);
        end
      end
      if (res_acc && !pass_last)
        pass <= pass + PW'(1);
      if (state == REPLAY) begin
        if (!rd_valid) begin
          rd_valid <= 1'b1;
        end else if (lane_rtr_i) begin
          if (rp_last) begin
            rd_valid <= 1'b0;
            rc       <= '0;
          end else begin
            rc <= rc + AW'(1);
          end
        end
      end
      if (state == DRAIN && rtr_i) begin
        if (drain_last) begin
          oc    <= '0;
          tlast <= 1'b0;
          pass  <= '0;
        end else begin
          oc <= oc + OW'(1);
        end
      end
    end
  end

  // outputs; held quiet while reset is asserted
  always_comb begin
    rtr_o        = 1'b0;
    lane_rts_o   = 1'b0;
    lane_sow_o   = 1'b0;
    lane_eow_o   = 1'b0;
    lane_posit_o = '0;
    lane_pass_o  = '0;
    rts_o        = 1'b0;
    eow_o        = 1'b0;
    posit_o      = '0;
    if (!rst_n) begin
      rtr_o = lane_rtr_i;
    end else begin
      lane_pass_o = pass;
      unique case (state)
        FILL: begin
          rtr_o        = lane_rtr_i;
          lane_rts_o   = rts_i;
          lane_posit_o = posit_i;
          lane_sow_o   = rts_i & (wc == '0);
          lane_eow_o   = rts_i & fill_last;
        end
        WAIT_RES: begin
        end
        REPLAY: begin
          lane_rts_o   = rd_valid;
          lane_posit_o = rd_valid ? rd_data : '0;
          lane_sow_o   = rd_valid & (rc == '0);
          lane_eow_o   = rd_valid & rp_last;
        end
        DRAIN: begin
          rts_o   = 1'b1;
          posit_o = drain_word;
          eow_o   = tlast & drain_last;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_positron_layer_folded.sv
// tb_positron_layer_folded: random frames through the folded layer,
// checked against a frame/result queue model with a lane monitor.
module tb_positron_layer_folded;
  localparam int W  = 16;
  localparam int NU = 6;
  localparam int L  = 2;
  localparam int P  = 3;
  localparam int NN = L * P;
  localparam int PW = $clog2(P) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rtr_o;
  logic           rts_i = 1'b0;
  logic           eow_i = 1'b0;
  logic [W-1:0]   posit_i = '0;
  logic           lane_rtr_i = 1'b1;
  logic           lane_rts_o;
  logic           lane_sow_o;
  logic           lane_eow_o;
  logic [W-1:0]   lane_posit_o;
  logic [PW-1:0]  lane_pass_o;
  logic           lane_res_rts_i = 1'b0;
  logic [L*W-1:0] lane_res_i = '0;
  logic           rtr_i = 1'b0;
  logic           rts_o;
  logic           eow_o;
  logic [W-1:0]   posit_o;

  positron_layer_folded #(
    .POSIT_WIDTH(W),
    .NB_UPSTREAM(NU),
    .NB_LANES(L),
    .NB_PASSES(P)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rtr_o(rtr_o),
    .rts_i(rts_i),
    .eow_i(eow_i),
    .posit_i(posit_i),
    .lane_rtr_i(lane_rtr_i),
    .lane_rts_o(lane_rts_o),
    .lane_sow_o(lane_sow_o),
    .lane_eow_o(lane_eow_o),
    .lane_posit_o(lane_posit_o),
    .lane_pass_o(lane_pass_o),
    .lane_res_rts_i(lane_res_rts_i),
    .lane_res_i(lane_res_i),
    .rtr_i(rtr_i),
    .rts_o(rts_o),
    .eow_o(eow_o),
    .posit_o(posit_o)
  );

  typedef struct {
    int         pass;
    bit         sow;
    bit         eow;
    logic [W-1:0] d;
  } lw_t;

  lw_t          mon_q[$];
  lw_t          mon_e;
  logic [W-1:0] frame[$];
  logic [W-1:0] expq[$];
  int           n_tests = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  // record every word a lane actually takes
  always @(negedge clk) begin
    if (lane_rts_o && lane_rtr_i) begin
      mon_e.pass = int'(lane_pass_o);
      mon_e.sow  = lane_sow_o;
      mon_e.eow  = lane_eow_o;
      mon_e.d    = lane_posit_o;
      mon_q.push_back(mon_e);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] w);
`ifdef POSITRON_LAYER_RELU_EN
    if (w[W-1] && w != 16'h8000) return '0;
`endif
    return w;
  endfunction

  function automatic logic [W-1:0] rand_res();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'hC000;
      2: return 16'h4000;
      3: return 16'h0000;
      default: return r[W-1:0];
    endcase
  endfunction

  task automatic check_pass(input int p, input int len);
    chk("pass_words", mon_q.size(), len);
    for (int j = 0; j < mon_q.size(); j++) begin
      chk("lane_data", mon_q[j].d, frame[j]);
      chk("lane_pass", mon_q[j].pass, p);
      chk("lane_sow", mon_q[j].sow, j == 0);
      chk("lane_eow", mon_q[j].eow, j == len - 1);
    end
    mon_q.delete();
  endtask

  task automatic do_reset();
    rts_i = 1'b0;
    rtr_i = 1'b0;
    lane_rtr_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_rts", rts_o, 0);
    chk("rst_lrts", lane_rts_o, 0);
    chk("rst_lsow", lane_sow_o, 0);
    chk("rst_leow", lane_eow_o, 0);
    chk("rst_lposit", lane_posit_o, 0);
    chk("rst_lpass", lane_pass_o, 0);
    chk("rst_eow", eow_o, 0);
    chk("rst_posit", posit_o, 0);
    chk("rst_rtr", rtr_o, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_pass", lane_pass_o, 0);
    chk("post_rst_rts", rts_o, 0);
    chk("post_rst_rtr", rtr_o, lane_rtr_i);
    mon_q.delete();
    expq.delete();
  endtask

  task automatic do_frame(input int len, input bit eow_last,
                          input int rst_pass);
    int i;
    int g;
    int w;
    int idx;
    logic [31:0] r32;
    logic [W-1:0] r;
    mon_q.delete();
    expq.delete();
    frame.delete();
    for (int k = 0; k < len; k++) begin
      r32 = $urandom;
      frame.push_back(r32[W-1:0]);
    end
    i = 0;
    g = 0;
    while (i < len && g < 400) begin
      rts_i = 1'b1;
      posit_i = frame[i];
      eow_i = eow_last && (i == len - 1);
      lane_rtr_i = ($urandom_range(0, 3) != 0);
      lane_res_rts_i = 1'($urandom_range(0, 1));
      lane_res_i = $urandom;
      #1;
      chk("fill_rtr", rtr_o, lane_rtr_i);
      @(posedge clk); #1;
      if (lane_rtr_i) i++;
      g++;
    end
    rts_i = 1'b0;
    eow_i = 1'b0;
    lane_res_rts_i = 1'b0;
    chk("fill_len", i, len);
    for (int p = 0; p < P; p++) begin
      if (p > 0) begin
        g = 0;
        while (mon_q.size() < len && g < 400) begin
          lane_rtr_i = ($urandom_range(0, 3) != 0);
          rts_i = 1'($urandom_range(0, 1));
          if (p == rst_pass && g == 2) begin
            do_reset();
            return;
          end
          #1;
          chk("replay_rtr", rtr_o, 0);
          @(posedge clk); #1;
          g++;
        end
      end
      check_pass(p, len);
      w = $urandom_range(0, 2);
      for (int k = 0; k < w; k++) begin
        rts_i = 1'b1;
        lane_rtr_i = 1'b1;
        #1;
        chk("wait_rtr", rtr_o, 0);
        chk("wait_lrts", lane_rts_o, 0);
        @(posedge clk); #1;
      end
      lane_res_rts_i = 1'b1;
      for (int k = 0; k < L; k++) begin
        r = rand_res();
        lane_res_i[k*W +: W] = r;
        expq.push_back(r);
      end
      @(posedge clk); #1;
      lane_res_rts_i = 1'b0;
      rts_i = 1'b0;
    end
    idx = 0;
    g = 0;
    while (idx < NN && g < 400) begin
      rtr_i = 1'($urandom_range(0, 1));
      #1;
      chk("drain_rts", rts_o, 1);
      chk("drain_data", posit_o, relu(expq[idx]));
      chk("drain_eow", eow_o, eow_last && idx == NN - 1);
      @(posedge clk); #1;
      if (rtr_i) idx++;
      g++;
    end
    rtr_i = 1'b0;
    chk("drain_cnt", idx, NN);
    chk("idle_rts", rts_o, 0);
    chk("idle_rtr", rtr_o, lane_rtr_i);
  endtask

  initial begin
    int len;
    bit el;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rtr", rtr_o, lane_rtr_i);
    chk("reset_rts", rts_o, 0);
    chk("reset_lrts", lane_rts_o, 0);
    chk("reset_pass", lane_pass_o, 0);
    chk("reset_eow", eow_o, 0);
    rst_n = 1'b1;
    #1;
    do_frame(NU, 1'b0, -1);
    do_frame(2, 1'b1, -1);
    do_frame(1, 1'b1, -1);
    do_frame(NU, 1'b1, -1);
    do_frame(3, 1'b1, 1);
    do_frame(4, 1'b1, -1);
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, NU);
      el = (len < NU) ? 1'b1 : 1'($urandom_range(0, 1));
      do_frame(len, el, -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
